alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single ALU instance between two requesters (Req0, Req1) via valid/ready handshakes.
//  Latches the winner's operands and control, drives the ALU, holds MUL for MUL_CYCLES, and returns
//  a registered result/Zero plus requester ID on one response channel. Sits between the issue
//  logic and the ALU.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; must match the ALU instance
//  MUL_CYCLES  4   cycles the ALU is held in EXEC for MUL (3'b101); >=1
// PORTS
//  CLK         in   1           clock, all state rising-edge
//  RST         in   1           asynchronous, active-high reset
//  Req0Valid   in   1           requester 0 has an operation
//  Req0Ready   out  1           requester 0 accepted this cycle
//  Req0SrcA    in   DATA_WIDTH  requester 0 operand A
//  Req0SrcB    in   DATA_WIDTH  requester 0 operand B
//  Req0Ctrl    in   3           requester 0 ALU control code
//  Req1*       --   --          identical set for requester 1
//  AluSrcA     out  DATA_WIDTH  to ALU SrcA (registered)
//  AluSrcB     out  DATA_WIDTH  to ALU SrcB (registered)
//  AluControl  out  3           to ALU ALUControl (registered)
//  AluResult   in   DATA_WIDTH  from ALU ALUResult
//  AluZero     in   1           from ALU Zero
//  RspValid    out  1           response available
//  RspReady    in   1           consumer takes response
//  RspId       out  1           requester that issued the operation
//  RspResult   out  DATA_WIDTH  captured ALU result
//  RspZero     out  1           captured ALU Zero
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; LastGrant=1 (Req0 wins first tie); cycle counter 0.
//  - FSM IDLE->EXEC->RESP->IDLE. One operation in flight; no overlap.
//  - IDLE: grant computed combinationally; ReqNReady=1 only for the granted requester with
//    ReqNValid=1; ready is 0 in EXEC/RESP. Handshake = Valid&Ready; on it latch SrcA/SrcB/Ctrl
//    into AluSrcA/AluSrcB/AluControl, record RspId, go EXEC. Requesters hold Valid/data until Ready.
//  - EXEC: non-MUL ops take 1 cycle; MUL holds EXEC for MUL_CYCLES cycles (counter 0..MUL_CYCLES-1).
//    Last EXEC cycle: capture AluResult/AluZero into RspResult/RspZero, go RESP.
//  - RESP: RspValid=1, RspResult/RspZero/RspId stable until RspValid&RspReady; then IDLE,
//    RspValid=0. Earliest next accept is the cycle after the response handshake.
//  - Latency (accept edge N): non-MUL RspValid at N+2; MUL at N+1+MUL_CYCLES.
//  - AluSrcA/B/Control retain last values in IDLE/RESP (no toggling).
//  - Undefined codes (3'b011, 3'b111) pass through unchanged; ALU yields 0, so RspResult=0, RspZero=1.
//  - Full result width only; MUL product truncated to DATA_WIDTH by the ALU.
//  - Reset mid-operation: FSM to IDLE immediately; in-flight op and pending response discarded.
//  - RspReady asserted while RspValid=0 is ignored.
// CONFIGURATION
//  ALU_ARB_RR_EN defined: round-robin; on simultaneous valids grant the requester other than
//    LastGrant; LastGrant updates on each accept. Single valid always wins.
//  ALU_ARB_RR_EN undefined: fixed priority, Req0 always wins ties; LastGrant unused/removed.
// STRUCTURE
//  - alu_pkg: ALU control codes (AND 000, OR 001, ADD 010, SUB 100, MUL 101, SLT 110), FSM
//    state encoding (IDLE/EXEC/RESP), requester-ID width.
//  - Sub-module alu_grant: 2-way grant logic (fixed or RR under ALU_ARB_RR_EN); FSM, operand
//    registers and response registers stay in alu_arbiter.
// TESTING
//  1. Req0 ADD 5+7, RspReady=1 -> Req0Ready at N, RspValid at N+2, RspResult=12, RspId=0, RspZero=0.
//  2. Req1 MUL 6*7, MUL_CYCLES=4 -> RspValid exactly at N+5, RspResult=42, RspId=1; Ready low meanwhile.
//  3. Both valid every cycle, RR_EN on -> RspId sequence 0,1,0,1; RR_EN off -> 0,0,0,0.
//  4. Req0 SUB 9-9, RspReady held 0 for 3 cycles -> RspValid/RspResult=0/RspZero=1 stable, no new accept.
//  5. RST pulsed during MUL EXEC -> all outputs 0 next edge, no response for that op; next req works.
//  6. Req0Ctrl=3'b111 -> RspResult=0, RspZero=1; SLT 3<8 -> RspResult=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes, arbiter FSM states and requester-ID type.
// Used by alu_grant and alu_arbiter (optional feature macro: ALU_ARB_RR_EN).
package alu_pkg;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b100;
  localparam logic [2:0] AluMul = 3'b101;
  localparam logic [2:0] AluSlt = 3'b110;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  localparam int unsigned IdWidth = 1;
  typedef logic [IdWidth-1:0] req_id_t;

endpackage

// File: rtl/alu_grant.sv
// Two-way grant for the ALU arbiter. Fixed priority (Req0 wins ties) by default;
// round-robin on ties when ALU_ARB_RR_EN is defined.
module alu_grant
  import alu_pkg::*;
(
`ifdef ALU_ARB_RR_EN
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    accept_i,
`endif
  input  logic    valid0_i,
  input  logic    valid1_i,
  output req_id_t grant_o
);

`ifdef ALU_ARB_RR_EN
  req_id_t last_grant_q;

  // On a tie hand the ALU to whoever did not win last; reset value 1 lets Req0 win first.
  always_comb begin
    if (valid0_i && valid1_i) begin
      grant_o = ~last_grant_q;
    end else begin
      grant_o = req_id_t'(valid1_i & ~valid0_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= req_id_t'(1'b1);
    end else if (accept_i) begin
      last_grant_q <= grant_o;
    end
  end
`else
  assign grant_o = req_id_t'(valid1_i & ~valid0_i);
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters: latches operands, holds MUL for
// MUL_CYCLES, returns a registered result. Tie policy selected by ALU_ARB_RR_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Req0Valid,
  output logic                  Req0Ready,
  input  logic [DATA_WIDTH-1:0] Req0SrcA,
  input  logic [DATA_WIDTH-1:0] Req0SrcB,
  input  logic [2:0]            Req0Ctrl,
  input  logic                  Req1Valid,
  output logic                  Req1Ready,
  input  logic [DATA_WIDTH-1:0] Req1SrcA,
  input  logic [DATA_WIDTH-1:0] Req1SrcB,
  input  logic [2:0]            Req1Ctrl,
  output logic [DATA_WIDTH-1:0] AluSrcA,
  output logic [DATA_WIDTH-1:0] AluSrcB,
  output logic [2:0]            AluControl,
  input  logic [DATA_WIDTH-1:0] AluResult,
  input  logic                  AluZero,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic                  RspId,
  output logic [DATA_WIDTH-1:0] RspResult,
  output logic                  RspZero
);

  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] alu_src_a_q, alu_src_b_q, rsp_result_q;
  logic [2:0]            alu_ctrl_q;
  logic                  rsp_valid_q, rsp_zero_q;
  req_id_t               rsp_id_q;

  req_id_t grant;
  logic    accept;
  logic    exec_done;

  alu_grant u_grant (
`ifdef ALU_ARB_RR_EN
    .clk_i    (CLK),
    .rst_i    (RST),
    .accept_i (accept),
`endif
    .valid0_i (Req0Valid),
    .valid1_i (Req1Valid),
    .grant_o  (grant)
  );

  assign Req0Ready = (state_q == StIdle) && Req0Valid && (grant == req_id_t'(1'b0));
  assign Req1Ready = (state_q == StIdle) && Req1Valid && (grant == req_id_t'(1'b1));
  assign accept    = Req0Ready | Req1Ready;
  assign exec_done = (alu_ctrl_q != AluMul) || (cnt_q == CntLast);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      alu_src_a_q  <= '0;
      alu_src_b_q  <= '0;
      alu_ctrl_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            alu_src_a_q <= grant[0] ? Req1SrcA : Req0SrcA;
            alu_src_b_q <= grant[0] ? Req1SrcB : Req0SrcB;
            alu_ctrl_q  <= grant[0] ? Req1Ctrl : Req0Ctrl;
            rsp_id_q    <= grant;
            cnt_q       <= '0;
            state_q     <= StExec;
          end
        end
        StExec: begin
          // The ALU is combinational on the held operands; sample it on the last EXEC cycle.
          if (exec_done) begin
            rsp_result_q <= AluResult;
            rsp_zero_q   <= AluZero;
            rsp_valid_q  <= 1'b1;
            cnt_q        <= '0;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          if (RspReady) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign AluSrcA    = alu_src_a_q;
  assign AluSrcB    = alu_src_b_q;
  assign AluControl = alu_ctrl_q;
  assign RspValid   = rsp_valid_q;
  assign RspId      = rsp_id_q[0];
  assign RspResult  = rsp_result_q;
  assign RspZero    = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (grant rule, ALU arithmetic, latency).
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned MC = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Req0Valid, Req0Ready, Req1Valid, Req1Ready;
  logic [DW-1:0] Req0SrcA, Req0SrcB, Req1SrcA, Req1SrcB;
  logic [2:0]    Req0Ctrl, Req1Ctrl;
  logic [DW-1:0] AluSrcA, AluSrcB, AluResult;
  logic [2:0]    AluControl;
  logic          AluZero;
  logic          RspValid, RspReady, RspId, RspZero;
  logic [DW-1:0] RspResult;

  alu_arbiter #(.DATA_WIDTH(DW), .MUL_CYCLES(MC)) dut (
    .CLK(CLK), .RST(RST),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0SrcA(Req0SrcA), .Req0SrcB(Req0SrcB),
    .Req0Ctrl(Req0Ctrl),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1SrcA(Req1SrcA), .Req1SrcB(Req1SrcB),
    .Req1Ctrl(Req1Ctrl),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluControl(AluControl),
    .AluResult(AluResult), .AluZero(AluZero),
    .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId),
    .RspResult(RspResult), .RspZero(RspZero)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [DW-1:0] ref_alu(input logic [2:0] c, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (c)
      AluAnd:  return a & b;
      AluOr:   return a | b;
      AluAdd:  return a + b;
      AluSub:  return a - b;
      AluMul:  return a * b;
      AluSlt:  return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      default: return '0;
    endcase
  endfunction

  // Environment ALU instance.
  assign AluResult = ref_alu(AluControl, AluSrcA, AluSrcB);
  assign AluZero   = (AluResult == '0);

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] opa[2], opb[2];
  logic [2:0]    opc[2];
  bit            pend[2];
  bit            model_last;

  task automatic drive_reqs();
    Req0Valid = pend[0]; Req0SrcA = opa[0]; Req0SrcB = opb[0]; Req0Ctrl = opc[0];
    Req1Valid = pend[1]; Req1SrcA = opa[1]; Req1SrcB = opb[1]; Req1Ctrl = opc[1];
  endtask

  task automatic set_op(input int r, input logic [2:0] c, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
    pend[r] = 1'b1; opc[r] = c; opa[r] = a; opb[r] = b;
  endtask

  task automatic new_op(input int r);
    logic [DW-1:0] a;
    a = $urandom;
    set_op(r, 3'($urandom_range(0, 7)), a, ($urandom_range(0, 3) == 0) ? a : DW'($urandom));
  endtask

  // One accept + response. Call at posedge+1; returns at posedge+1 after the response handshake.
  task automatic transact(input int hold, input bit early, output bit w,
                          output logic [DW-1:0] res, output logic z);
    int t0, lat, busy;
    bit got;
    logic [DW-1:0] ea, eb, er;
    logic [2:0] ec;
    logic ez;
    drive_reqs();
    if (pend[0] && pend[1]) begin
`ifdef ALU_ARB_RR_EN
      w = ~model_last;
`else
      w = 1'b0;
`endif
    end else begin
      w = pend[1];
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge CLK);
      got = Req0Ready | Req1Ready;
    end
    check("accept_seen", got, 1);
    res = '0; z = 1'b0;
    if (!got) return;
    check("grant", {Req1Ready, Req0Ready}, w ? 2'b10 : 2'b01);
    check("rsp_idle", RspValid, 0);
    ea = opa[w]; eb = opb[w]; ec = opc[w];
    er = ref_alu(ec, ea, eb);
    ez = (er == '0);
`ifdef ALU_ARB_RR_EN
    model_last = w;
`endif
    t0 = cyc;
    @(posedge CLK); #1;
    pend[w] = 1'b0;
    drive_reqs();
    if (early) RspReady = 1'b1;
    got = 1'b0; busy = 0;
    for (int i = 0; i < int'(MC) + 6 && !got; i++) begin
      @(negedge CLK);
      got = RspValid;
      if (Req0Ready | Req1Ready) busy++;
    end
    check("rsp_seen", got, 1);
    if (!got) begin
      RspReady = 1'b0;
      return;
    end
    lat = cyc - t0;
    check("latency", lat, (ec == AluMul) ? 1 + MC : 2);
    check("ready_busy", busy, 0);
    check("alu_ops", {AluControl, AluSrcA, AluSrcB}, {ec, ea, eb});
    check("rsp_id", RspId, w);
    check("rsp_result", RspResult, er);
    check("rsp_zero", RspZero, ez);
    res = RspResult; z = RspZero;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check("rsp_hold", {Req0Ready, Req1Ready, RspValid, RspId, RspZero, RspResult},
            {2'b00, 1'b1, w, ez, er});
    end
    RspReady = 1'b1;
    @(posedge CLK); #1;
    RspReady = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit w;
    bit seen;
    bit ids[4];
    logic [DW-1:0] res;
    logic z;

    RST = 1'b1; RspReady = 1'b0; model_last = 1'b1;
    pend[0] = 0; pend[1] = 0;
    opa[0] = '0; opb[0] = '0; opc[0] = '0; opa[1] = '0; opb[1] = '0; opc[1] = '0;
    drive_reqs();
    repeat (2) @(negedge CLK);
    check("reset_state", {Req0Ready, Req1Ready, RspValid, RspId, RspZero, RspResult,
                          AluControl, AluSrcA, AluSrcB}, '0);
    @(posedge CLK); #1; RST = 1'b0;

    // ADD 5+7 with the consumer already ready.
    set_op(0, AluAdd, 5, 7);
    transact(0, 1'b1, w, res, z);
    check("t1_result", {w, z, res}, {1'b0, 1'b0, DW'(12)});

    // MUL 6*7 from Req1.
    set_op(1, AluMul, 6, 7);
    transact(0, 1'b0, w, res, z);
    check("t2_result", {w, res}, {1'b1, DW'(42)});

    // Both requesters valid back to back.
    new_op(0); new_op(1);
    for (int k = 0; k < 4; k++) begin
      transact(0, 1'b0, w, res, z);
      ids[k] = w;
      if (k < 3) new_op(int'(w));
    end
`ifdef ALU_ARB_RR_EN
    check("t3_ids", {ids[0], ids[1], ids[2], ids[3]}, 4'b0101);
`else
    check("t3_ids", {ids[0], ids[1], ids[2], ids[3]}, 4'b0000);
`endif
    while (pend[0] || pend[1]) transact(0, 1'b0, w, res, z);

    // SUB 9-9 with response back-pressure.
    set_op(0, AluSub, 9, 9);
    transact(3, 1'b0, w, res, z);
    check("t4_result", {z, res}, {1'b1, DW'(0)});

    // Reset in the middle of a MUL.
    set_op(0, AluMul, 6, 7);
    drive_reqs();
    @(negedge CLK);
    check("t5_accept", Req0Ready, 1);
    @(posedge CLK); #1;
    pend[0] = 1'b0;
    drive_reqs();
    @(posedge CLK); #2;
    RST = 1'b1;
    @(negedge CLK);
    check("t5_rst_outputs", {Req0Ready, Req1Ready, RspValid, RspId, RspZero, RspResult,
                             AluControl, AluSrcA, AluSrcB}, '0);
    @(posedge CLK); #1;
    RST = 1'b0;
    model_last = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < int'(MC) + 3; i++) begin
      @(negedge CLK);
      if (RspValid) seen = 1'b1;
    end
    check("t5_no_rsp", seen, 0);
    @(posedge CLK); #1;
    set_op(0, AluOr, 32'h00f0, 32'h0f00);
    transact(0, 1'b0, w, res, z);
    check("t5_after", res, DW'(32'h0ff0));

    // Undefined codes and SLT.
    set_op(0, 3'b111, 32'h1234, 32'h5678);
    transact(0, 1'b0, w, res, z);
    check("t6_undef7", {z, res}, {1'b1, DW'(0)});
    set_op(1, 3'b011, 32'hffff, 32'h1);
    transact(1, 1'b0, w, res, z);
    check("t6_undef3", {z, res}, {1'b1, DW'(0)});
    set_op(0, AluSlt, 3, 8);
    transact(0, 1'b0, w, res, z);
    check("t6_slt", {z, res}, {1'b0, DW'(1)});

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      bit early;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) new_op(r);
      end
      if (!pend[0] && !pend[1]) new_op(int'($urandom_range(0, 1)));
      early = ($urandom_range(0, 3) == 0);
      transact(early ? 0 : int'($urandom_range(0, 2)), early, w, res, z);
    end
    while (pend[0] || pend[1]) transact(0, 1'b0, w, res, z);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
